sequence_checker: RTL and testbench

//  Holds the random tile sequence for one round of the memory game and judges player presses against it.

---
 rtl/sequence_checker.sv | 184 ++++++++++++++++++
 tb/tb_sequence_checker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// sequence_checker: generates the LFSR tile sequence for one memory-game round
// and judges synchronised, edge-detected player key presses against it.
module sequence_checker #(
    parameter int unsigned MAX_LEN     = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       randomEnable,
    input  logic [4:0] difficulty,
    input  logic [5:0] sequence_counter,
    input  logic       playerEN,
    input  logic       checkEN,
    input  logic [3:0] player_keys,
    output logic [1:0] seq_tile,
    output logic [1:0] correct_tile,
    output logic       player_input,
    output logic       check,
    output logic [4:0] player_index,
    output logic       round_done,
    output logic       gen_busy
);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {IDLE, GEN, READY, ARMED, PENDING} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q;
    logic        ren_q, plen_q;
    logic [3:0]  sync_q [SYNC_STAGES];
    logic [3:0]  kprev_q;
    logic [4:0]  len_q, len_d, len_new;
    logic [4:0]  gen_idx_q, gen_idx_d;
    logic [4:0]  pidx_q, pidx_d;
    logic        done_q, done_d;
    logic        pin_q, pin_d;
    logic        chk_q, chk_d;
    logic        fail_q, fail_d;
    logic        busy_q, busy_d;
    logic [1:0]  cap_q, cap_d;
    logic [1:0]  corr_q, corr_d;
    logic [1:0]  mem [MAX_LEN];

    logic        start, press_ok, mem_we;
    logic [3:0]  key_now, fall;
    logic [1:0]  press_tile, exp_tile;
    logic [AW-1:0] waddr, rd_idx;

    assign start    = randomEnable & ~ren_q;
    assign key_now  = sync_q[SYNC_STAGES-1];
    assign fall     = kprev_q & ~key_now;
    assign len_new  = (difficulty > 5'(MAX_LEN)) ? 5'(MAX_LEN) : difficulty;
    assign press_ok = (|fall) && plen_q && ((state_q == READY) || (state_q == ARMED));
    assign exp_tile = mem[AW'(pidx_q)];
    assign mem_we   = start || (state_q == GEN);
    assign waddr    = start ? '0 : AW'(gen_idx_q);
    assign rd_idx   = AW'(sequence_counter % 6'(MAX_LEN));

    // Downward scan so the lowest falling bit is the last assignment and wins.
    always_comb begin
        press_tile = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (fall[i]) press_tile = 2'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        gen_idx_d = gen_idx_q;
        pidx_d    = pidx_q;
        done_d    = done_q;
        pin_d     = pin_q;
        chk_d     = chk_q;
        fail_d    = fail_q;
        busy_d    = busy_q;
        cap_d     = cap_q;
        corr_d    = corr_q;
        if (start) begin
            len_d     = len_new;
            gen_idx_d = 5'd1;
            pidx_d    = '0;
            done_d    = 1'b0;
            pin_d     = 1'b0;
            chk_d     = 1'b0;
            fail_d    = 1'b0;
            if (len_new <= 5'd1) begin
                busy_d  = 1'b0;
                state_d = READY;
            end else begin
                busy_d  = 1'b1;
                state_d = GEN;
            end
        end else begin
            case (state_q)
                GEN: begin
                    if (gen_idx_q + 5'd1 >= len_q) begin
                        busy_d  = 1'b0;
                        state_d = READY;
                    end else begin
                        gen_idx_d = gen_idx_q + 5'd1;
                    end
                end
                READY, ARMED: begin
                    if (press_ok) begin
                        cap_d   = press_tile;
                        pin_d   = 1'b1;
                        chk_d   = (press_tile == exp_tile) && (pidx_q < len_q) && !done_q && !fail_q;
                        state_d = PENDING;
                    end else begin
                        state_d = plen_q ? ARMED : READY;
                    end
                end
                PENDING: begin
                    if (checkEN) begin
                        pin_d   = 1'b0;
                        state_d = READY;
                        if (chk_q) begin
                            corr_d = cap_q;
                            pidx_d = pidx_q + 5'd1;
                            done_d = (pidx_q + 5'd1 == len_q);
                        end else begin
                            fail_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            ren_q     <= 1'b0;
            plen_q    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            kprev_q   <= '1;
            len_q     <= '0;
            gen_idx_q <= '0;
            pidx_q    <= '0;
            done_q    <= 1'b0;
            pin_q     <= 1'b0;
            chk_q     <= 1'b0;
            fail_q    <= 1'b0;
            busy_q    <= 1'b0;
            cap_q     <= '0;
            corr_q    <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            ren_q     <= randomEnable;
            plen_q    <= playerEN;
            sync_q[0] <= player_keys;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            kprev_q   <= key_now;
            len_q     <= len_d;
            gen_idx_q <= gen_idx_d;
            pidx_q    <= pidx_d;
            done_q    <= done_d;
            pin_q     <= pin_d;
            chk_q     <= chk_d;
            fail_q    <= fail_d;
            busy_q    <= busy_d;
            cap_q     <= cap_d;
            corr_q    <= corr_d;
        end
    end

    // Sequence memory carries no reset; its contents are meaningless until regenerated.
    always_ff @(posedge clock) begin
        if (mem_we) mem[waddr] <= lfsr_q[1:0];
    end

    assign seq_tile     = mem[rd_idx];
    assign correct_tile = corr_q;
    assign player_input = pin_q;
    assign check        = chk_q;
    assign player_index = pidx_q;
    assign round_done   = done_q;
    assign gen_busy     = busy_q;
endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: randomized rounds judged against a behavioural game model.
module tb_sequence_checker;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       randomEnable = 1'b0;
    logic [4:0] difficulty = 5'd0;
    logic [5:0] sequence_counter = 6'd0;
    logic       playerEN = 1'b0;
    logic       checkEN = 1'b0;
    logic [3:0] player_keys = 4'hF;
    logic [1:0] seq_tile, correct_tile;
    logic       player_input, check, round_done, gen_busy;
    logic [4:0] player_index;

    int checks = 0;
    int errors = 0;

    sequence_checker dut (
        .clock(clock), .resetn(resetn), .randomEnable(randomEnable),
        .difficulty(difficulty), .sequence_counter(sequence_counter),
        .playerEN(playerEN), .checkEN(checkEN), .player_keys(player_keys),
        .seq_tile(seq_tile), .correct_tile(correct_tile), .player_input(player_input),
        .check(check), .player_index(player_index), .round_done(round_done),
        .gen_busy(gen_busy)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Free-running reference of the generator state.
    logic [15:0] m_lfsr;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) m_lfsr <= SEED;
        else         m_lfsr <= lfsr_next(m_lfsr);
    end

    // Game model
    logic [1:0] exp_seq [16];
    int         m_len, m_pidx;
    bit         m_done, m_fail, m_pend, m_chk;
    logic [1:0] m_tile, m_corr;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic build_model(input logic [4:0] diff, input bit from_seed);
        logic [15:0] v;
        v = from_seed ? SEED : m_lfsr;
        m_len = (diff > 5'd16) ? 16 : int'(diff);
        for (int i = 0; i < 16; i++) begin
            exp_seq[i] = v[1:0];
            v = lfsr_next(v);
        end
        m_pidx = 0; m_done = 0; m_fail = 0; m_pend = 0; m_chk = 0;
    endtask

    task automatic begin_gen(input logic [4:0] diff, input bit from_seed);
        build_model(diff, from_seed);
        difficulty   = diff;
        randomEnable = 1'b1;
        @(negedge clock);
        randomEnable = 1'b0;
    endtask

    task automatic wait_gen(input string tag);
        for (int i = 0; i < 40 && gen_busy; i++) @(negedge clock);
        cmp({tag, "_gen_done"}, gen_busy, 1'b0);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < m_len; i++) begin
            sequence_counter = 6'(i);
            #1;
            cmp({tag, "_mem"}, seq_tile, exp_seq[i]);
        end
        sequence_counter = 6'd0;
    endtask

    task automatic press(input logic [3:0] mask, input bit expect_cap, input string tag);
        bit seen;
        player_keys = player_keys & ~mask;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (player_input) seen = 1;
        end
        cmp({tag, "_capture"}, seen, expect_cap);
        if (expect_cap) begin
            m_tile = 2'd0;
            for (int b = 3; b >= 0; b--) if (mask[b]) m_tile = 2'(b);
            m_chk  = (m_pidx < m_len) && !m_done && !m_fail && (m_tile == exp_seq[m_pidx % 16]);
            m_pend = 1;
            cmp({tag, "_check"}, check, m_chk);
        end
    endtask

    task automatic release_keys(input logic [3:0] mask);
        player_keys = player_keys | mask;
        repeat (4) @(negedge clock);
    endtask

    task automatic strobe(input string tag);
        checkEN = 1'b1;
        @(negedge clock);
        checkEN = 1'b0;
        if (m_pend) begin
            if (m_chk) begin
                m_corr = m_tile;
                m_pidx++;
                m_done = (m_pidx == m_len);
            end else begin
                m_fail = 1;
            end
            m_pend = 0;
        end
        cmp({tag, "_pin_clear"}, player_input, 1'b0);
        cmp({tag, "_pidx"}, player_index, m_pidx);
        cmp({tag, "_done"}, round_done, m_done);
        cmp({tag, "_corr"}, correct_tile, m_corr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic [3:0] mk, other;
        int w;
        logic [4:0] diffs [3];
        diffs[0] = 5'd3; diffs[1] = 5'd6; diffs[2] = 5'd9;
        m_corr = 2'd0;

        // Reset state
        repeat (3) @(negedge clock);
        cmp("rst_gen_busy", gen_busy, 1'b0);
        cmp("rst_pin", player_input, 1'b0);
        cmp("rst_check", check, 1'b0);
        cmp("rst_pidx", player_index, 5'd0);
        cmp("rst_done", round_done, 1'b0);
        cmp("rst_corr", correct_tile, 2'd0);

        // T1: start right at reset release, randomEnable held 2 cycles
        resetn = 1'b1;
        build_model(5'd3, 1);
        difficulty   = 5'd3;
        randomEnable = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 0) cmp("t1_tile0_next_cycle", seq_tile, exp_seq[0]);
            if (i == 1) randomEnable = 1'b0;
            if (gen_busy) busy_cnt++;
        end
        cmp("t1_busy_cycles", busy_cnt, 2);
        check_mem("t1");

        // T2: full correct rounds with random difficulty
        playerEN = 1'b1;
        for (int r = 0; r < 2; r++) begin
            begin_gen(diffs[$urandom_range(0, 2)], 0);
            wait_gen("t2");
            check_mem("t2");
            for (int i = 0; i < m_len; i++) begin
                mk = 4'(1 << exp_seq[i]);
                press(mk, 1, "t2");
                release_keys(mk);
                strobe("t2");
            end
            cmp("t2_round_done", round_done, 1'b1);
            mk = 4'(1 << $urandom_range(0, 3));
            press(mk, 1, "t2_after_done");
            release_keys(mk);
            strobe("t2_after_done");
        end

        // T3: wrong press latches failure until next generation
        begin_gen(5'd3, 0);
        wait_gen("t3");
        w  = (int'(exp_seq[0]) + 1 + int'($urandom_range(0, 2))) % 4;
        mk = 4'(1 << w);
        press(mk, 1, "t3_wrong");
        release_keys(mk);
        strobe("t3_wrong");
        mk = 4'(1 << exp_seq[0]);
        press(mk, 1, "t3_late_right");
        release_keys(mk);
        strobe("t3_late_right");

        // T4: simultaneous KEY1+KEY2, prefer a round where the check tells them apart
        for (int a = 0; a < 20; a++) begin
            begin_gen(5'd3, 0);
            wait_gen("t4");
            if (exp_seq[0] == 2'd1 || exp_seq[0] == 2'd2) break;
        end
        press(4'b0110, 1, "t4_both");
        strobe("t4_both");
        repeat (8) @(negedge clock);
        cmp("t4_held_no_capture", player_input, 1'b0);
        release_keys(4'b0100);
        press(4'b0100, 1, "t4_repress");
        release_keys(4'b0110);
        strobe("t4_repress");

        // T5: dropped presses
        player_keys = player_keys & ~4'b0100;
        begin_gen(5'd9, 0);
        wait_gen("t5");
        repeat (4) @(negedge clock);
        cmp("t5_gen_drop", player_input, 1'b0);
        release_keys(4'b0100);
        playerEN = 1'b0;
        repeat (2) @(negedge clock);
        press(4'(1 << exp_seq[0]), 0, "t5_noen");
        release_keys(4'hF);
        playerEN = 1'b1;
        repeat (2) @(negedge clock);
        mk    = 4'(1 << exp_seq[0]);
        other = 4'(1 << ((int'(exp_seq[0]) + 1 + int'($urandom_range(0, 2))) % 4));
        press(mk, 1, "t5_first");
        player_keys = player_keys & ~other;
        repeat (6) @(negedge clock);
        cmp("t5_pending_hold", player_input, 1'b1);
        release_keys(4'hF);
        strobe("t5_pending");
        cmp("t5_pidx_unchanged_by_drop", player_index, 5'd1);

        // T6: reset in the middle of generation
        begin_gen(5'd9, 0);
        repeat (3) @(negedge clock);
        cmp("t6_busy_before_reset", gen_busy, 1'b1);
        resetn = 1'b0;
        #1;
        m_corr = 2'd0;
        cmp("t6_rst_busy", gen_busy, 1'b0);
        cmp("t6_rst_pidx", player_index, 5'd0);
        cmp("t6_rst_corr", correct_tile, 2'd0);
        cmp("t6_rst_pin", player_input, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        begin_gen(5'd9, 1);
        wait_gen("t6");
        check_mem("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
